four_bit_serial_subtractor: RTL and testbench

Bit-serial 4-bit subtractor with borrow-in/borrow-out. It computes D = A − B − Bin one bit per clock through a single registered full-subtractor cell, LSB first. It is the inverse-direction companion to the team's 4-bit ripple adder in the arithmetic datapath. A start/busy/done handshake lets a controller issue operands and collect the result together with status flags.

---
 rtl/four_bit_serial_subtractor.sv | 123 ++++++++++++
 tb/tb_four_bit_serial_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial 4-bit subtractor: D = A - B - Bin, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow. A
// start/busy/done handshake frames each operation; result flags are
// registered and hold until the next operation completes.
module four_bit_serial_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] D,
    output logic       Bout,
    output logic       V,
    output logic       Z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  a_q;
    logic [3:0]  b_q;
    logic        br_q;
    logic [3:0]  res_q;
    logic [1:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  dOut_q;
    logic        boutOut_q;
    logic        vOut_q;
    logic        zOut_q;

    logic        diffBit_d;
    logic        brNext_d;
    logic [3:0]  res_d;

    // Full-subtractor cell on the current LSBs plus the result shifted in from the MSB side
    always_comb begin
        diffBit_d = a_q[0] ^ b_q[0] ^ br_q;
        brNext_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d     = {diffBit_d, res_q[3:1]};
    end

    // Control FSM, operand/result shifting and registered outputs; reset wins over start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            br_q      <= 1'b0;
            res_q     <= 4'd0;
            cnt_q     <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dOut_q    <= 4'd0;
            boutOut_q <= 1'b0;
            vOut_q    <= 1'b0;
            zOut_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        br_q    <= Bin;
                        cnt_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= {1'b0, a_q[3:1]};
                    b_q   <= {1'b0, b_q[3:1]};
                    br_q  <= brNext_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        dOut_q    <= res_d;
                        boutOut_q <= brNext_d;
                        vOut_q    <= br_q ^ brNext_d;
                        zOut_q    <= (res_d == 4'd0);
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        br_q    <= Bin;
                        cnt_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = dOut_q;
    assign Bout = boutOut_q;
    assign V    = vOut_q;
    assign Z    = zOut_q;

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Scoreboard bench for four_bit_serial_subtractor: stimulus pushes expected
// results (value, flags and the cycle done must appear in) into a queue; a
// monitor pops and compares on every done pulse.
module tb_four_bit_serial_subtractor;

    typedef struct {
        logic [3:0] d;
        logic       bout;
        logic       v;
        logic       z;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Bin;
    logic       busy;
    logic       done;
    logic [3:0] D;
    logic       Bout;
    logic       V;
    logic       Z;

    exp_t sbQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    four_bit_serial_subtractor dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .V     (V),
        .Z     (Z)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: during cycle N (sampled at negedge) cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t refModel(input logic [3:0] a, input logic [3:0] b,
                                      input logic bin, input int doneCyc);
        exp_t e;
        int   u;
        int   s;
        u = int'(a) - int'(b) - int'(bin);
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.d    = u[3:0];
        e.bout = (u < 0);
        e.v    = (s > 7) || (s < -8);
        e.z    = (u[3:0] == 4'd0);
        e.cyc  = doneCyc;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Issue one operation at the current negedge (cycle N); returns at the
    // negedge of cycle N+5 so the next call is back-to-back with done.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic bin);
        A = a;
        B = b;
        Bin = bin;
        start = 1'b1;
        sbQ.push_back(refModel(a, b, bin, cyc + 5));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                A = 4'($urandom);
                B = 4'($urandom);
                Bin = 1'($urandom);
            end
            checkOutput("busy_during_shift", int'(busy), 1);
            checkOutput("done_during_shift", int'(done), 0);
        end
        @(negedge clk);
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (busy && done) begin
            checks++;
            errors++;
            $display("[TB] FAIL busy_and_done: both high in cycle %0d", cyc);
        end
        if (done) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done with empty scoreboard, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("done_cycle", cyc, e.cyc);
                checkOutput("D", int'(D), int'(e.d));
                checkOutput("Bout", int'(Bout), int'(e.bout));
                checkOutput("V", int'(V), int'(e.v));
                checkOutput("Z", int'(Z), int'(e.z));
            end
        end
    end

    // Main stimulus sequence
    initial begin
        rst = 1'b1;
        start = 1'b0;
        A = 4'd0;
        B = 4'd0;
        Bin = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_D", int'(D), 0);
        checkOutput("reset_Bout", int'(Bout), 0);
        checkOutput("reset_V", int'(V), 0);
        checkOutput("reset_Z", int'(Z), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the operation rules
        applyStimulus(4'd9, 4'd3, 1'b0);
        applyStimulus(4'd3, 4'd9, 1'b0);
        applyStimulus(4'd7, 4'd8, 1'b0);
        applyStimulus(4'd5, 4'd5, 1'b0);
        applyStimulus(4'd5, 4'd5, 1'b1);
        repeat (3) @(negedge clk);

        // start re-pulsed in cycle 2 must be ignored
        A = 4'd12;
        B = 4'd4;
        Bin = 1'b1;
        start = 1'b1;
        sbQ.push_back(refModel(4'd12, 4'd4, 1'b1, cyc + 5));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'd0;
        B = 4'd1;
        Bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        // back-to-back start in the done cycle
        applyStimulus(4'd2, 4'd14, 1'b1);
        repeat (2) @(negedge clk);

        // Reset in cycle 3 of an operation aborts it with no done pulse
        A = 4'd15;
        B = 4'd0;
        Bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_D", int'(D), 0);
        checkOutput("midreset_Z", int'(Z), 0);
        checkOutput("midreset_Bout", int'(Bout), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Exhaustive back-to-back sweep
        for (int bin = 0; bin < 2; bin++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    applyStimulus(4'(a), 4'(b), 1'(bin));
        repeat (2) @(negedge clk);

        // Randomized operations with random idle gaps
        for (int n = 0; n < 60; n++) begin
            applyStimulus(4'($urandom), 4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
